// File: rtl/alu_serial_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_seq_if
// Description : Bit-serial link between the sequencer and a 1-bit ALU slice.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_serial_seq_if;
    logic       bit_a;
    logic       bit_b;
    logic       bit_cin;
    logic       bit_ctrl;
    logic       bit_less;
    logic [5:0] bit_signal;
    logic       bit_out;
    logic       bit_cout;
    logic       bit_set;

    // Sequencer side drives operands and controls, slice side returns results
    modport master (
        output bit_a, bit_b, bit_cin, bit_ctrl, bit_less, bit_signal,
        input  bit_out, bit_cout, bit_set
    );

    modport slave (
        input  bit_a, bit_b, bit_cin, bit_ctrl, bit_less, bit_signal,
        output bit_out, bit_cout, bit_set
    );
endinterface
`default_nettype wire

// File: rtl/alu_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_seq
// Description : Drives a 1-bit ALU slice LSB first to build a WIDTH-bit result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  wire               clk,
    input  wire               rst_n,
    input  wire               start,
    input  wire  [5:0]        funct,
    input  wire  [WIDTH-1:0]  op_a,
    input  wire  [WIDTH-1:0]  op_b,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              overflow,
    output logic              err,
    alu_serial_seq_if.master  slc
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] c_FN_ADD = 6'd32;
    localparam logic [5:0] c_FN_SUB = 6'd34;
    localparam logic [5:0] c_FN_AND = 6'd36;
    localparam logic [5:0] c_FN_OR  = 6'd37;
    localparam logic [5:0] c_FN_SLT = 6'd42;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic             r_cq;
    logic             r_sq;
    logic [5:0]       r_funct;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_acc;
    logic [WIDTH-1:0] w_acc_cat;
    logic [WIDTH-1:0] w_final;
    logic             w_supported;
    logic             w_last;
    logic             w_is_sub;
    logic             w_is_slt;
    logic             w_is_arith;
    logic             w_ovf;
    logic             w_err;

    assign w_supported = (funct == c_FN_ADD) || (funct == c_FN_SUB) ||
                         (funct == c_FN_AND) || (funct == c_FN_OR)  ||
                         (funct == c_FN_SLT);
    assign w_last      = (r_idx == IDX_W'(WIDTH - 1));
    assign w_is_slt    = (r_funct == c_FN_SLT);
    assign w_is_sub    = (r_funct == c_FN_SUB) || w_is_slt;
    assign w_is_arith  = (r_funct == c_FN_ADD) || (r_funct == c_FN_SUB);

    assign busy = (r_state != c_ST_IDLE);
    assign done = (r_state == c_ST_DONE);

    // Result bits enter at the top and walk down; SLT accumulates zeros
    assign w_acc_cat = {(w_is_slt ? 1'b0 : slc.bit_out), r_acc};

    always_comb begin
        slc.bit_a      = 1'b0;
        slc.bit_b      = 1'b0;
        slc.bit_cin    = 1'b0;
        slc.bit_ctrl   = 1'b0;
        slc.bit_less   = 1'b0;
        slc.bit_signal = 6'd0;
        if (r_state == c_ST_RUN) begin
            slc.bit_a      = r_a[0];
            slc.bit_b      = r_b[0];
            slc.bit_ctrl   = w_is_sub;
            slc.bit_cin    = (r_idx == '0) ? w_is_sub : r_cq;
            slc.bit_signal = w_is_slt ? c_FN_SUB : r_funct;
        end else if (r_state == c_ST_FIX) begin
            slc.bit_signal = c_FN_SLT;
            slc.bit_less   = r_sq;
            slc.bit_ctrl   = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_nxt = w_supported ? c_ST_RUN : c_ST_DONE;
            c_ST_RUN:  if (w_last) w_state_nxt = w_is_slt ? c_ST_FIX : c_ST_DONE;
            c_ST_FIX:  w_state_nxt = c_ST_DONE;
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Values latched on the way into DONE; only RUN, FIX or a rejected start get there
    always_comb begin
        w_final = '0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                w_final = w_acc_cat;
                w_ovf   = w_is_arith & (r_cq ^ slc.bit_cout);
            end
            c_ST_FIX:  w_final = {{(WIDTH-1){1'b0}}, slc.bit_out};
            c_ST_IDLE: w_err   = 1'b1;
            default:   w_final = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_idx    <= '0;
            r_cq     <= 1'b0;
            r_sq     <= 1'b0;
            r_funct  <= 6'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_ST_IDLE: begin
                    if (start && w_supported) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_funct <= funct;
                        r_idx   <= '0;
                        r_cq    <= 1'b0;
                        r_sq    <= 1'b0;
                        r_acc   <= '0;
                    end
                end
                c_ST_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_cq  <= slc.bit_cout;
                    r_acc <= w_acc_cat[WIDTH-1:1];
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_sq <= slc.bit_set;
                    end
                end
                default: ;
            endcase
            if (w_state_nxt == c_ST_DONE) begin
                result   <= w_final;
                zero     <= (w_final == '0);
                overflow <= w_ovf;
                err      <= w_err;
            end
        end
    end

endmodule
`default_nettype wire
